// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port between the I-cache (port 0)
// and D-cache (port 1) controllers; each grant covers one whole line burst.
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_mem_arbiter #(
    parameter int OFFSET_WIDTH = `CACHE_B
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_i,
    input  logic [1:0]              we_i,
    input  logic [31:0]             addr0_i,
    input  logic [31:0]             addr1_i,
    input  logic [31:0]             wdata0_i,
    input  logic [31:0]             wdata1_i,
    output logic [1:0]              gnt_o,
    output logic [1:0]              beat_valid_o,
    output logic [1:0]              done_o,
    output logic [OFFSET_WIDTH-3:0] beat_idx_o,
    output logic [31:0]             rdata_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_addr_o,
    output logic [31:0]             mem_wdata_o,
    input  logic [31:0]             mem_rdata_i,
    input  logic                    mem_ready_i
);

    localparam int BW = OFFSET_WIDTH - 2;
    localparam logic [BW-1:0] LAST_BEAT = '1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_reg;
    logic            owner_reg;
    logic            last_owner_reg;
    logic [1:0]      gnt_reg;
    logic [BW-1:0]   beat_reg;

    logic            winner;
    logic            in_burst;
    logic            accept;
    logic            last_beat;
    logic [31:0]     own_addr;
    logic [31:0]     own_wdata;
    logic            own_we;
    logic            unused_addr_bits;

    // On a tie the port that did not own the previous burst wins.
    always_comb begin
        winner = 1'b0;
        if (req_i == 2'b11)
            winner = ~last_owner_reg;
        else if (req_i[1])
            winner = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            gnt_reg        <= 2'b00;
            beat_reg       <= '0;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_i != 2'b00) begin
                        owner_reg <= winner;
                        gnt_reg   <= winner ? 2'b10 : 2'b01;
                        beat_reg  <= '0;
                        state_reg <= BURST;
                    end
                end
                BURST: begin
                    if (mem_ready_i) begin
                        if (beat_reg == LAST_BEAT) begin
                            state_reg      <= IDLE;
                            gnt_reg        <= 2'b00;
                            beat_reg       <= '0;
                            last_owner_reg <= owner_reg;
                        end else begin
                            beat_reg <= beat_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_burst  = (state_reg == BURST);
    // Pulses are suppressed in a reset cycle so an aborted burst never reports done.
    assign accept    = in_burst & mem_ready_i & ~rst_i;
    assign last_beat = accept & (beat_reg == LAST_BEAT);

    assign own_addr  = owner_reg ? addr1_i  : addr0_i;
    assign own_wdata = owner_reg ? wdata1_i : wdata0_i;
    assign own_we    = we_i[owner_reg];

    assign gnt_o       = gnt_reg;
    assign beat_idx_o  = beat_reg;
    assign rdata_o     = mem_rdata_i;
    assign mem_en_o    = in_burst;
    assign mem_we_o    = in_burst & own_we;
    assign mem_addr_o  = in_burst ? {own_addr[31:OFFSET_WIDTH], beat_reg, 2'b00} : 32'd0;
    assign mem_wdata_o = in_burst ? own_wdata : 32'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign beat_valid_o[gi] = accept    & (owner_reg == 1'(gi));
            assign done_o[gi]       = last_beat & (owner_reg == 1'(gi));
        end
    endgenerate

    assign unused_addr_bits = ^{addr0_i[OFFSET_WIDTH-1:0], addr1_i[OFFSET_WIDTH-1:0]};

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed line bursts plus random traffic against a burst-level model.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    localparam int OW   = 4;
    localparam int LINE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0] req, we;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
    logic mem_ready;
    logic [1:0] gnt, bv, done;
    logic [OW-3:0] bidx;
    logic [31:0] rdata, maddr, mwdata;
    logic men, mwe;

    cache_mem_arbiter #(.OFFSET_WIDTH(OW)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt_o(gnt), .beat_valid_o(bv), .done_o(done), .beat_idx_o(bidx),
        .rdata_o(rdata), .mem_en_o(men), .mem_we_o(mwe), .mem_addr_o(maddr),
        .mem_wdata_o(mwdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Burst-level model: is a burst running, for whom, and how many beats are done.
    bit m_busy  = 1'b0;
    bit m_owner = 1'b0;
    bit m_last  = 1'b1;
    int m_beat  = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_beat <= 0;
            m_last <= 1'b1;
        end else if (m_busy) begin
            if (mem_ready) begin
                if (m_beat == LINE - 1) begin
                    m_busy <= 1'b0;
                    m_beat <= 0;
                    m_last <= m_owner;
                end else begin
                    m_beat <= m_beat + 1;
                end
            end
        end else if (req != 2'b00) begin
            m_owner <= (req == 2'b11) ? !m_last : req[1];
            m_busy  <= 1'b1;
            m_beat  <= 0;
        end
    end

    always @(negedge clk) begin : cmp
        logic [31:0] own_a, own_d, exp_addr;
        logic [1:0]  exp_gnt, pulse;
        if (chk_en) begin
            own_a    = m_owner ? addr1 : addr0;
            own_d    = m_owner ? wdata1 : wdata0;
            exp_gnt  = m_busy ? (2'b01 << m_owner) : 2'b00;
            pulse    = (m_busy && mem_ready && !rst) ? exp_gnt : 2'b00;
            exp_addr = m_busy ? ((own_a & ~32'(LINE * 4 - 1)) + 32'(m_beat * 4)) : 32'd0;
            chk("gnt", gnt, exp_gnt);
            chk("beat_valid", bv, pulse);
            chk("done", done, (m_beat == LINE - 1) ? pulse : 2'b00);
            chk("mem_en", men, m_busy);
            chk("mem_we", mwe, m_busy ? we[m_owner] : 1'b0);
            chk("mem_addr", maddr, exp_addr);
            chk("mem_wdata", mwdata, m_busy ? own_d : 32'd0);
            chk("beat_idx", bidx, 32'(m_beat));
            chk("rdata", rdata, mem_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fill_addr [4] = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C};
    logic [1:0]  rr_gnt [14]   = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10,
                                   2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    logic        wb_ready [8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] wb_addr [8]   = '{32'h2000_0010, 32'h2000_0014, 32'h2000_0014, 32'h2000_0014,
                                   32'h2000_0018, 32'h2000_0018, 32'h2000_0018, 32'h2000_001C};

    initial begin : stim
        int npulse;
        bit act [2];
        logic [1:0] dn, g;
        rst = 1'b1; req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0; mem_rdata = '0; mem_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        chk("reset_gnt", gnt, 2'b00);
        chk("reset_mem_en", men, 1'b0);
        tick();

        // Single I-cache fill
        rst = 1'b0; req = 2'b01; we = 2'b00; addr0 = 32'h1000_0004; mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fill_gnt", gnt, 2'b01);
            chk("fill_addr", maddr, fill_addr[k]);
            chk("fill_bv", bv, 2'b01);
            chk("fill_done", done, (k == 3) ? 2'b01 : 2'b00);
            tick();
        end
        req = 2'b00;
        @(negedge clk);
        chk("fill_idle_gnt", gnt, 2'b00);
        chk("fill_idle_en", men, 1'b0);

        // Both ports from reset alternate with one idle cycle between bursts
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 2'b11; addr0 = 32'h1000_0040; addr1 = 32'h2000_0080;
        tick();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            chk("rr_gnt", gnt, rr_gnt[c]);
            tick();
        end
        req = 2'b00;

        // D-cache write-back with stalls
        req = 2'b10; we = 2'b10; addr1 = 32'h2000_0010; wdata1 = 32'hCAFE_F00D;
        tick();
        npulse = 0;
        for (int c = 0; c < 8; c++) begin
            mem_ready = wb_ready[c];
            @(negedge clk);
            chk("wb_addr", maddr, wb_addr[c]);
            chk("wb_we", mwe, 1'b1);
            chk("wb_wdata", mwdata, 32'hCAFE_F00D);
            if (bv[1]) npulse++;
            if (c == 7) chk("wb_done", done, 2'b10);
            tick();
        end
        chk("wb_pulses", npulse, 4);
        req = 2'b00; we = 2'b00; mem_ready = 1'b1;

        // req_i[1] dropped mid-burst
        req = 2'b10; addr1 = 32'h2000_0100;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 2) req = 2'b00;
            @(negedge clk);
            if (c == 3) chk("drop_done", done, 2'b10);
            tick();
        end

        // Port 0 burst leaves last owner = 0, then reset aborts the next burst on beat 2
        req = 2'b01; addr0 = 32'h3000_0000;
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tick();
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_done", done, 2'b00);
        chk("rst_bv", bv, 2'b00);
        tick();
        rst = 1'b0; req = 2'b11;
        @(negedge clk);
        chk("post_rst_gnt", gnt, 2'b00);
        chk("post_rst_en", men, 1'b0);
        tick();
        @(negedge clk);
        chk("tie_after_rst", gnt, 2'b01);
        tick();
        rst = 1'b1; req = 2'b00;
        tick();
        rst = 1'b0;

        // Random traffic
        act[0] = 1'b0; act[1] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            dn = done;
            g  = gnt;
            @(posedge clk);
            #1;
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = $urandom;
            wdata0    = $urandom;
            wdata1    = $urandom;
            rst       = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < 2; p++) begin
                if (rst || (act[p] && dn[p])) begin
                    act[p] = 1'b0;
                    req[p] = 1'b0;
                end else if (!act[p] && $urandom_range(0, 3) == 0) begin
                    act[p] = 1'b1;
                    req[p] = 1'b1;
                    we[p]  = 1'($urandom_range(0, 1));
                    if (p == 0) addr0 = $urandom;
                    else        addr1 = $urandom;
                end else if (act[p] && g[p] && $urandom_range(0, 15) == 0) begin
                    req[p] = 1'b0;
                end
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter OFFSET_WIDTH, default `CACHE_B, byte-offset width of one cache line; LINE_SIZE = 2**(OFFSET_WIDTH-2) words per burst.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk_i  in  1  clock; all state updates on posedge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 req_i  in  2  burst request per port; bit 0 is the I-cache controller, bit 1 is the D-cache controller.
REQ-006 we_i  in  2  per port: 1 = write-back burst, 0 = line-fill burst.
REQ-007 addr0_i, addr1_i  in  32 each  line address per port; bits [OFFSET_WIDTH-1:0] ignored.
REQ-008 wdata0_i, wdata1_i  in  32 each  write word per port for the current beat_idx_o.
REQ-009 gnt_o  out  2  one-hot; owner of the memory port for the whole burst.
REQ-010 beat_valid_o  out  2  one-cycle pulse on the owner bit when a beat is accepted by memory.
REQ-011 done_o  out  2  one-cycle pulse on the owner bit with the last accepted beat.
REQ-012 beat_idx_o  out  OFFSET_WIDTH-2  current word index within the line.
REQ-013 rdata_o  out  32  mem_rdata_i forwarded unregistered.
REQ-014 mem_en_o, mem_we_o  out  1 each  memory access strobe and write enable.
REQ-015 mem_addr_o  out  32  word address to memory.
REQ-016 mem_wdata_o  out  32  owner's write word.
REQ-017 mem_rdata_i  in  32  read word, valid when mem_ready_i=1.
REQ-018 mem_ready_i  in  1  memory accepts/completes the beat this cycle.

Function
REQ-019 States: IDLE, BURST; state, owner, last_owner, and beat counter are registers.
REQ-020 IDLE: if req_i!=0, select the winner, register owner, set gnt_o next cycle, clear the beat counter, and enter BURST; no memory access in IDLE.
REQ-021 Arbitration is round-robin: if both request, the port != last_owner wins; a single requester always wins.
REQ-022 BURST: mem_en_o=1, mem_we_o=we_i[owner], mem_addr_o={addr_owner[31:OFFSET_WIDTH], beat_idx_o, 2'b00}, mem_wdata_o=wdata of owner.
REQ-023 BURST with mem_ready_i=1: beat_valid_o[owner]=1 that cycle, and the beat counter increments; with mem_ready_i=0 all outputs hold and no pulse occurs.
REQ-024 Accepted beat with beat_idx_o==LINE_SIZE-1: done_o[owner]=1 same cycle; next cycle state=IDLE, gnt_o=0, last_owner<=owner.
REQ-025 Minimum spacing: one IDLE cycle between consecutive bursts; back-to-back bursts alternate when both ports hold req_i.
REQ-026 Requesters hold req_i, we_i, and addr until done_o; req_i deasserted mid-burst is ignored and the burst completes.
REQ-027 Outside BURST: mem_en_o, mem_we_o, beat_valid_o, and done_o are 0; mem_addr_o and mem_wdata_o are 0.
REQ-028 The beat counter wraps only via return to IDLE; it never exceeds LINE_SIZE-1.

Reset
REQ-029 rst_i=1 forces the following next edge, regardless of state: state=IDLE, gnt_o=0, beat counter=0, last_owner=1 (port 0 wins the first tie).
REQ-030 Reset mid-burst aborts without done_o; memory outputs are 0 from the cycle after reset.
REQ-031 While rst_i=1, all pulses are 0.

Verification
REQ-032 Single I-cache fill, LINE_SIZE=4, addr0=0x1000_0004, mem_ready=1 -> gnt_o=01, mem_addr 0x1000_0000/04/08/0C, four beat_valid_o[0] pulses, done_o[0] on 4th, IDLE next.
REQ-033 Both ports request from reset -> port 0 first, then port 1 after one IDLE cycle, then port 0 again.
REQ-034 D-cache write-back with mem_ready low on beats 1 and 2 for 2 cycles each -> addresses/wdata held, exactly 4 beat_valid_o[1] pulses over 8 cycles, mem_we_o=1 throughout.
REQ-035 req_i[1] drops after beat 1 -> burst still completes with done_o[1].
REQ-036 rst_i asserted on beat 2 -> no done_o, gnt_o=0 and mem_en_o=0 next cycle, next tie goes to port 0.
